// File: rtl/mcp3008_throttle_reader_if.sv
// Purpose: signal bundle between the MCP3008 throttle reader and its environment.
//   The bundle carries the SPI pins (AD_CLK, CS, DIN, DOUT), the enable control and the
//   published result (adc_raw, accel, sample_valid, busy, null_err).
//   master modport: the reader side (drives SPI and results, sees enable/DOUT).
//   slave modport : the environment side (drives enable/DOUT, sees everything else).
interface mcp3008_throttle_reader_if;
    logic       enable;
    logic       AD_CLK;
    logic       CS;
    logic       DIN;
    logic       DOUT;
    logic [9:0] adc_raw;
    logic [9:0] accel;
    logic       sample_valid;
    logic       busy;
    logic       null_err;

    modport master (
        input  enable, DOUT,
        output AD_CLK, CS, DIN, adc_raw, accel, sample_valid, busy, null_err
    );

    modport slave (
        output enable, DOUT,
        input  AD_CLK, CS, DIN, adc_raw, accel, sample_valid, busy, null_err
    );
endinterface

// File: rtl/mcp3008_throttle_reader.sv
// Purpose: SPI master for an MCP3008 10-bit ADC. It converts one channel back-to-back
//   and maps the raw code to a clamped accel value for the commutation/PWM block.
// Ports:
//   clk  - system clock
//   rst  - asynchronous reset, active-high
//   bus  - mcp3008_throttle_reader_if.master:
//          enable (in), DOUT (in), AD_CLK/CS/DIN (out),
//          adc_raw/accel (out, 10b), sample_valid/busy/null_err (out)
module mcp3008_throttle_reader #(
    parameter int unsigned CLK_DIV      = 675,
    parameter int unsigned CHANNEL      = 4,
    parameter int unsigned SINGLE_ENDED = 1,
    parameter int unsigned GAP_TICKS    = 2,
    parameter int unsigned THR_LO       = 280,
    parameter int unsigned THR_HI       = 780,
    parameter int unsigned ACCEL_GAIN   = 2,
    parameter int unsigned ACCEL_MAX    = 1000
) (
    input  logic                          clk,
    input  logic                          rst,
    mcp3008_throttle_reader_if.master     bus
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned GAP_W = $clog2(GAP_TICKS + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_END  = GAP_W'(GAP_TICKS);
    localparam logic [2:0]       CH       = 3'(CHANNEL);
    localparam logic             SGL      = 1'(SINGLE_ENDED);

    // Tick indices inside a frame
    localparam logic [5:0] T_NULL  = 6'd13;   // rising edge 7
    localparam logic [5:0] T_DATA0 = 6'd15;   // rising edge 8 (B9)
    localparam logic [5:0] T_LAST  = 6'd34;

    typedef enum logic [1:0] {
        IDLE,
        FRAME,
        GAP
    } state_t;

    state_t           state, state_d;
    logic [DIV_W-1:0] div_cnt, div_cnt_d;
    logic [5:0]       t_cnt, t_cnt_d;
    logic [GAP_W-1:0] gap_cnt, gap_cnt_d;
    logic [9:0]       shift, shift_d;
    logic             null_bit, null_bit_d;
    logic             pub, pub_d;
    logic             ad_clk, ad_clk_d;
    logic             cs, cs_d;
    logic             din, din_d;
    logic             busy, busy_d;
    logic [9:0]       adc_raw, adc_raw_d;
    logic [9:0]       accel, accel_d;
    logic             sample_valid, sample_valid_d;
    logic             null_err, null_err_d;
    logic             tick_c;
    logic             start_c;

    // Raw code to accel: dead band below THR_LO, linear slope, clamp to ACCEL_MAX
    function automatic logic [9:0] map_accel(input logic [9:0] r);
        logic [11:0] r12;
        logic [11:0] diff;
        logic [11:0] prod;
        logic [11:0] res;
        r12  = 12'(r);
        diff = r12 - 12'(THR_LO);
        prod = 12'(diff * 12'(ACCEL_GAIN));
        if (r12 <= 12'(THR_LO)) begin
            res = 12'd0;
        end else if (r12 > 12'(THR_HI)) begin
            res = 12'(ACCEL_MAX);
        end else if (prod > 12'(ACCEL_MAX)) begin
            res = 12'(ACCEL_MAX);
        end else begin
            res = prod;
        end
        return 10'(res);
    endfunction

    assign tick_c = (div_cnt == DIV_LAST);

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            div_cnt      <= '0;
            t_cnt        <= '0;
            gap_cnt      <= '0;
            shift        <= '0;
            null_bit     <= 1'b0;
            pub          <= 1'b0;
            ad_clk       <= 1'b0;
            cs           <= 1'b1;
            din          <= 1'b0;
            busy         <= 1'b0;
            adc_raw      <= '0;
            accel        <= '0;
            sample_valid <= 1'b0;
            null_err     <= 1'b0;
        end else begin
            state        <= state_d;
            div_cnt      <= div_cnt_d;
            t_cnt        <= t_cnt_d;
            gap_cnt      <= gap_cnt_d;
            shift        <= shift_d;
            null_bit     <= null_bit_d;
            pub          <= pub_d;
            ad_clk       <= ad_clk_d;
            cs           <= cs_d;
            din          <= din_d;
            busy         <= busy_d;
            adc_raw      <= adc_raw_d;
            accel        <= accel_d;
            sample_valid <= sample_valid_d;
            null_err     <= null_err_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d        = state;
        div_cnt_d      = tick_c ? '0 : div_cnt + DIV_W'(1);
        t_cnt_d        = t_cnt;
        gap_cnt_d      = gap_cnt;
        shift_d        = shift;
        null_bit_d     = null_bit;
        pub_d          = 1'b0;
        ad_clk_d       = ad_clk;
        cs_d           = cs;
        din_d          = din;
        busy_d         = busy;
        adc_raw_d      = adc_raw;
        accel_d        = accel;
        sample_valid_d = 1'b0;
        null_err_d     = null_err;
        start_c        = 1'b0;

        // Result stage, one clk after the last frame tick
        if (pub) begin
            if (!null_bit) begin
                adc_raw_d      = shift;
                accel_d        = map_accel(shift);
                sample_valid_d = 1'b1;
                null_err_d     = 1'b0;
            end else begin
                null_err_d     = 1'b1;
            end
        end

        case (state)
            IDLE: begin
                cs_d     = 1'b1;
                ad_clk_d = 1'b0;
                if (tick_c && bus.enable) begin
                    start_c = 1'b1;
                end
            end
            FRAME: begin
                if (tick_c) begin
                    t_cnt_d = t_cnt + 6'd1;
                    if (t_cnt[0]) begin
                        // Rising SCLK: sample DOUT (it changed on the previous fall)
                        ad_clk_d = 1'b1;
                        if (t_cnt == T_NULL) begin
                            null_bit_d = bus.DOUT;
                        end else if (t_cnt >= T_DATA0) begin
                            shift_d = {shift[8:0], bus.DOUT};
                        end
                    end else begin
                        // Falling SCLK: present the command bit for the next rising edge
                        ad_clk_d = 1'b0;
                        case (t_cnt)
                            6'd2:    din_d = SGL;
                            6'd4:    din_d = CH[2];
                            6'd6:    din_d = CH[1];
                            6'd8:    din_d = CH[0];
                            default: din_d = 1'b0;
                        endcase
                        if (t_cnt == T_LAST) begin
                            cs_d      = 1'b1;
                            busy_d    = 1'b0;
                            pub_d     = 1'b1;
                            gap_cnt_d = '0;
                            state_d   = GAP;
                        end
                    end
                end
            end
            GAP: begin
                if (tick_c) begin
                    // After GAP_TICKS idle ticks, this tick is either t=0 or a drop to IDLE
                    if (gap_cnt == GAP_END) begin
                        if (bus.enable) begin
                            start_c = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        gap_cnt_d = gap_cnt + GAP_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Frame tick t=0: select chip, start bit on DIN
        if (start_c) begin
            state_d  = FRAME;
            t_cnt_d  = 6'd1;
            cs_d     = 1'b0;
            busy_d   = 1'b1;
            din_d    = 1'b1;
            ad_clk_d = 1'b0;
        end
    end

    assign bus.AD_CLK       = ad_clk;
    assign bus.CS           = cs;
    assign bus.DIN          = din;
    assign bus.adc_raw      = adc_raw;
    assign bus.accel        = accel;
    assign bus.sample_valid = sample_valid;
    assign bus.busy         = busy;
    assign bus.null_err     = null_err;

endmodule

// File: tb/tb_mcp3008_throttle_reader.sv
// Purpose: directed self-checking bench for mcp3008_throttle_reader with a behavioural
//   MCP3008 (CLK_DIV=2, GAP_TICKS=2, channel 4 single-ended).
// Ports: none (top-level bench).
module tb_mcp3008_throttle_reader;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    mcp3008_throttle_reader_if bus();

    mcp3008_throttle_reader #(
        .CLK_DIV      (2),
        .CHANNEL      (4),
        .SINGLE_ENDED (1),
        .GAP_TICKS    (2),
        .THR_LO       (280),
        .THR_HI       (780),
        .ACCEL_GAIN   (2),
        .ACCEL_MAX    (1000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural MCP3008: counts rising SCLK edges, shifts DOUT on falling edges
    logic [9:0] m_raw;
    logic       m_null;
    logic [4:0] m_cmd;
    int         m_cnt;
    logic       m_prev_clk;
    logic       m_prev_cs;

    always @(negedge clk) begin
        m_prev_clk <= bus.AD_CLK;
        m_prev_cs  <= bus.CS;
        if (rst) begin
            m_cnt    <= 0;
            bus.DOUT <= 1'b0;
        end else if (m_prev_cs && !bus.CS) begin
            m_cnt <= 0;
        end else if (!bus.CS && !m_prev_clk && bus.AD_CLK) begin
            m_cnt <= m_cnt + 1;
            if (m_cnt < 5) m_cmd <= {m_cmd[3:0], bus.DIN};
        end else if (!bus.CS && m_prev_clk && !bus.AD_CLK) begin
            if (m_cnt == 6) bus.DOUT <= m_null;
            else if (m_cnt >= 7 && m_cnt <= 16) bus.DOUT <= m_raw[16 - m_cnt];
        end
    end

    // Overall time limit
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog");
    end

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.sample_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_level(input bit want_busy, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.busy == want_busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst        = 1'b1;
        bus.enable = 1'b0;
        m_raw      = 10'd0;
        m_null     = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if ({bus.CS, bus.AD_CLK, bus.DIN} !== 3'b100) begin
            fails++;
            $display("FAIL reset_spi: got CS/AD_CLK/DIN=%b required 100", {bus.CS, bus.AD_CLK, bus.DIN});
        end
        tests++;
        if ({bus.adc_raw, bus.accel} !== 20'd0) begin
            fails++;
            $display("FAIL reset_data: got adc_raw=%0d accel=%0d required 0/0", bus.adc_raw, bus.accel);
        end
        tests++;
        if ({bus.sample_valid, bus.busy, bus.null_err} !== 3'b000) begin
            fails++;
            $display("FAIL reset_flags: got valid/busy/null_err=%b required 000",
                     {bus.sample_valid, bus.busy, bus.null_err});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        bit ok;
        m_raw      = 10'd530;
        m_null     = 1'b0;
        bus.enable = 1'b1;
        wait_valid(300, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL basic_timeout: got no sample_valid required a pulse within 300 clk");
        end
        tests++;
        if (bus.adc_raw !== 10'd530) begin
            fails++;
            $display("FAIL basic_raw: got %0d required 530", bus.adc_raw);
        end
        tests++;
        if (bus.accel !== 10'd500) begin
            fails++;
            $display("FAIL basic_accel: got %0d required 500", bus.accel);
        end
        tests++;
        if (m_cmd !== 5'b11100) begin
            fails++;
            $display("FAIL basic_cmd: got DIN bits %b required 11100", m_cmd);
        end
        @(negedge clk);
        tests++;
        if (bus.sample_valid !== 1'b0) begin
            fails++;
            $display("FAIL basic_pulse_width: got sample_valid=%b one clk later required 0", bus.sample_valid);
        end
    endtask

    task automatic test_sweep;
        logic [9:0] raws [6];
        logic [9:0] exps [6];
        bit ok;
        raws = '{10'd100, 10'd280, 10'd281, 10'd780, 10'd781, 10'd1023};
        exps = '{10'd0,   10'd0,   10'd2,   10'd1000, 10'd1000, 10'd1000};
        for (int i = 0; i < 6; i++) begin
            m_raw = raws[i];
            wait_valid(300, ok);
            tests++;
            if (!ok || bus.adc_raw !== raws[i] || bus.accel !== exps[i]) begin
                fails++;
                $display("FAIL sweep_%0d: got valid=%0d raw=%0d accel=%0d required raw=%0d accel=%0d",
                         i, ok, bus.adc_raw, bus.accel, raws[i], exps[i]);
            end
        end
    endtask

    task automatic test_null_bit;
        bit ok;
        int pulses;
        m_raw  = 10'd77;
        m_null = 1'b1;
        wait_level(1'b1, 200, ok);
        pulses = 0;
        for (int i = 0; i < 200 && bus.busy; i++) begin
            @(negedge clk);
            if (bus.sample_valid) pulses++;
        end
        repeat (3) begin
            @(negedge clk);
            if (bus.sample_valid) pulses++;
        end
        tests++;
        if (bus.null_err !== 1'b1) begin
            fails++;
            $display("FAIL null_err_set: got %b required 1", bus.null_err);
        end
        tests++;
        if (bus.adc_raw !== 10'd1023 || bus.accel !== 10'd1000 || pulses != 0) begin
            fails++;
            $display("FAIL null_hold: got raw=%0d accel=%0d pulses=%0d required 1023/1000/0",
                     bus.adc_raw, bus.accel, pulses);
        end
        m_raw  = 10'd600;
        m_null = 1'b0;
        wait_valid(300, ok);
        tests++;
        if (!ok || bus.null_err !== 1'b0 || bus.adc_raw !== 10'd600 || bus.accel !== 10'd640) begin
            fails++;
            $display("FAIL null_recover: got valid=%0d null_err=%b raw=%0d accel=%0d required 1/0/600/640",
                     ok, bus.null_err, bus.adc_raw, bus.accel);
        end
    endtask

    task automatic test_back_to_back;
        int  t_fall [3];
        int  n;
        int  busy_len;
        int  busy_run;
        int  mism;
        bit  prev_cs;
        bit  prev_busy;
        n         = 0;
        busy_len  = -1;
        busy_run  = 0;
        mism      = 0;
        prev_cs   = bus.CS;
        prev_busy = bus.busy;
        for (int cyc = 0; cyc < 400 && n < 3; cyc++) begin
            @(negedge clk);
            if (prev_cs && !bus.CS) begin
                t_fall[n] = cyc;
                n++;
            end
            if (bus.busy !== !bus.CS) mism++;
            if (bus.busy) busy_run++;
            if (prev_busy && !bus.busy && n > 0) busy_len = busy_run;
            if (!bus.busy) busy_run = 0;
            prev_cs   = bus.CS;
            prev_busy = bus.busy;
        end
        tests++;
        if (n != 3) begin
            fails++;
            $display("FAIL b2b_frames: got %0d CS falls required 3", n);
        end else begin
            tests++;
            if (t_fall[1] - t_fall[0] != 74 || t_fall[2] - t_fall[1] != 74) begin
                fails++;
                $display("FAIL b2b_period: got %0d and %0d clk required 74",
                         t_fall[1] - t_fall[0], t_fall[2] - t_fall[1]);
            end
        end
        tests++;
        if (busy_len != 68) begin
            fails++;
            $display("FAIL b2b_busy_len: got %0d clk required 68 (ticks 0..34)", busy_len);
        end
        tests++;
        if (mism != 0) begin
            fails++;
            $display("FAIL b2b_busy_cs: got %0d cycles with busy != !CS required 0", mism);
        end
    endtask

    task automatic test_enable_drop;
        bit ok;
        int cs_lows;
        wait_level(1'b0, 200, ok);
        m_raw = 10'd333;
        wait_level(1'b1, 200, ok);
        for (int i = 0; i < 200 && m_cnt != 9; i++) @(negedge clk);
        bus.enable = 1'b0;
        wait_valid(300, ok);
        tests++;
        if (!ok || bus.adc_raw !== 10'd333 || bus.accel !== 10'd106) begin
            fails++;
            $display("FAIL drop_result: got valid=%0d raw=%0d accel=%0d required 1/333/106",
                     ok, bus.adc_raw, bus.accel);
        end
        cs_lows = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!bus.CS || bus.busy) cs_lows++;
        end
        tests++;
        if (cs_lows != 0) begin
            fails++;
            $display("FAIL drop_idle: got %0d cycles with CS low or busy required 0", cs_lows);
        end
    endtask

    task automatic test_reset_mid_frame;
        bit ok;
        m_raw      = 10'd900;
        bus.enable = 1'b1;
        wait_level(1'b1, 200, ok);
        for (int i = 0; i < 200 && m_cnt < 10; i++) @(negedge clk);
        rst = 1'b1;
        #1;
        tests++;
        if (bus.CS !== 1'b1 || bus.AD_CLK !== 1'b0) begin
            fails++;
            $display("FAIL midrst_spi: got CS=%b AD_CLK=%b required 1/0", bus.CS, bus.AD_CLK);
        end
        tests++;
        if ({bus.DIN, bus.sample_valid, bus.busy, bus.null_err} !== 4'b0000 ||
            {bus.adc_raw, bus.accel} !== 20'd0) begin
            fails++;
            $display("FAIL midrst_outputs: got din/valid/busy/null=%b raw=%0d accel=%0d required 0000/0/0",
                     {bus.DIN, bus.sample_valid, bus.busy, bus.null_err}, bus.adc_raw, bus.accel);
        end
        @(negedge clk);
        rst = 1'b0;
        ok  = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!bus.CS) begin
                ok = 1'b1;
                break;
            end
        end
        tests++;
        if (!ok || bus.DIN !== 1'b1 || bus.AD_CLK !== 1'b0 || bus.busy !== 1'b1) begin
            fails++;
            $display("FAIL midrst_restart: got cs_low=%0d DIN=%b AD_CLK=%b busy=%b required 1/1/0/1",
                     ok, bus.DIN, bus.AD_CLK, bus.busy);
        end
        wait_valid(300, ok);
        tests++;
        if (!ok || bus.adc_raw !== 10'd900 || bus.accel !== 10'd1000 || m_cmd !== 5'b11100) begin
            fails++;
            $display("FAIL midrst_frame: got valid=%0d raw=%0d accel=%0d cmd=%b required 1/900/1000/11100",
                     ok, bus.adc_raw, bus.accel, m_cmd);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_basic();
        test_sweep();
        test_null_bit();
        test_back_to_back();
        test_enable_drop();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
